// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter. The host pushes bytes at clock rate.
// A three-state drain FSM hands one byte at a time to the transmitter's
// din/wr_en inputs and paces on its tx_busy flag.
module uart_tx_fifo #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int BUSY_TO = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [7:0]    wr_data,
   input  logic          wr_valid,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [7:0]    tx_din,
   output logic          tx_wr_en,
   input  logic          tx_busy
);

   localparam int TW = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [AW:0]     w_count_nxt;
   logic            r_full;
   logic            r_empty;
   logic            r_overflow;
   logic [7:0]      r_tx_din;
   logic            r_tx_wr_en;
   logic [TW-1:0]   r_to_cnt;
   logic            w_wr_acc;
   logic            w_pop;
   logic            w_to_inc;

   // A write is accepted only against the registered full flag, so a pop in the
   // same cycle never frees a slot for a write made while full.
   assign w_wr_acc = wr_valid && !r_full;

   // Drain FSM state register.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create order-dependent races.
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Drain FSM next state plus pop and timeout-advance decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise paths
      // that do not assign it would infer a latch.
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_to_inc    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!r_empty && !tx_busy) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            // If busy never rises, the byte is treated as sent after BUSY_TO cycles.
            if (tx_busy)                 w_state_nxt = S_WAIT_DONE;
            else if (r_to_cnt == TO_LAST) w_state_nxt = S_IDLE;
            else                          w_to_inc    = 1'b1;
         end
         S_WAIT_DONE: begin
            if (!tx_busy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Occupancy after this edge. A simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_wr_acc, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Byte storage.
   always_ff @(posedge CLK) begin
      // NOTE: the memory array is deliberately not reset. Only the pointers and
      // count define which entries are valid, so stale contents are harmless.
      if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
   end

   // Pointers, status flags, transmitter handshake and timeout counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
         r_tx_din   <= 8'h00;
         r_tx_wr_en <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_tx_din <= r_mem[r_rd_ptr];
            r_to_cnt <= '0;
         end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         r_tx_wr_en <= w_pop;
         r_overflow <= wr_valid && r_full;
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CNT_MAX);
         r_empty    <= (w_count_nxt == '0);
      end
   end

   assign full     = r_full;
   assign empty    = r_empty;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign tx_din   = r_tx_din;
   assign tx_wr_en = r_tx_wr_en;

endmodule
